// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Sequential binary-to-packed-BCD converter using shift-and-add-3
// (double dabble), one input bit per clock. The bcd output register keeps
// the previous result stable while a new conversion runs, so a downstream
// seven-segment driver never shows intermediate values.
//
// Parameters:
//    WIDTH   binary input width (default 14, covers 0..9999)
//    DIGITS  number of BCD digits produced (output is 4*DIGITS bits)
//
// Ports:
//    clk       system clock, rising edge
//    reset     synchronous, active-high reset
//    start     conversion request, sampled only in IDLE
//    bin       unsigned binary input, captured on the accepted start cycle
//    bcd       packed BCD result, digit k in bits [4k+3:4k]
//    busy      high while a conversion is in progress
//    done      one-cycle pulse when a new result first appears on bcd
//    overflow  last captured bin was >= 10**DIGITS (bcd saturated to all 9s)
//
// Optional build macro:
//    BCD_AUTO_REFRESH_EN  when defined, start is ignored and a conversion is
//                         launched whenever bin differs from the last captured
//                         value while the block is idle.
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   // Smallest value that no longer fits in DIGITS decimal digits.
   localparam longint unsigned BCD_LIMIT = 64'(10) ** DIGITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  bin_cap_reg, bin_cap_next;   // captured value, kept for overflow test
   logic [WIDTH-1:0]  shift_reg, shift_next;       // binary half of the double-dabble register
   logic [BW-1:0]     scratch_reg, scratch_next;   // BCD half of the double-dabble register
   logic [BW-1:0]     scratch_adj;                 // scratch after the add-3 correction
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [BW-1:0]     bcd_reg, bcd_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              overflow_reg, overflow_next;
   logic              conv_req;
   logic              over_limit;

`ifdef BCD_AUTO_REFRESH_EN
   // start is kept on the port list but has no influence; the masked term
   // only keeps it referenced.
   assign conv_req = (bin != bin_cap_reg) || (start && 1'b0);
`else
   assign conv_req = start;
`endif

   assign over_limit = (64'(bin_cap_reg) >= BCD_LIMIT);

   // Add 3 to every digit that is 5 or more, all digits in parallel, so the
   // following left shift carries correctly into the next decimal digit.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                         scratch_reg[4*gi +: 4] + 4'd3 :
                                         scratch_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      bin_cap_next  = bin_cap_reg;
      shift_next    = shift_reg;
      scratch_next  = scratch_reg;
      cnt_next      = cnt_reg;
      bcd_next      = bcd_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      overflow_next = overflow_reg;

      case (state_reg)
         IDLE: begin
            if (conv_req) begin
               bin_cap_next = bin;
               shift_next   = bin;
               scratch_next = '0;
               cnt_next     = CW'(WIDTH);
               busy_next    = 1'b1;
               state_next   = SHIFT;
            end
         end

         SHIFT: begin
            {scratch_next, shift_next} = {scratch_adj, shift_reg} << 1;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               busy_next  = 1'b0;
               state_next = FINISH;
            end
         end

         FINISH: begin
            if (over_limit) begin
               bcd_next      = {DIGITS{4'h9}};
               overflow_next = 1'b1;
            end else begin
               bcd_next      = scratch_reg;
               overflow_next = 1'b0;
            end
            done_next  = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         bin_cap_reg  <= '0;
         shift_reg    <= '0;
         scratch_reg  <= '0;
         cnt_reg      <= '0;
         bcd_reg      <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bin_cap_reg  <= bin_cap_next;
         shift_reg    <= shift_next;
         scratch_reg  <= scratch_next;
         cnt_reg      <= cnt_next;
         bcd_reg      <= bcd_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         overflow_reg <= overflow_next;
      end
   end

   assign bcd      = bcd_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_converter
//
// Directed self-checking bench for bin_to_bcd_converter (default build,
// WIDTH=14, DIGITS=4). Expected values are hand-computed constants.
// Timing reference: start sampled at edge N -> busy from N, done and new bcd
// after edge N+15, busy low in the FINISH cycle after edge N+14.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [13:0] bin;
   logic [15:0] bcd;
   logic        busy;
   logic        done;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   bin_to_bcd_converter #(.WIDTH(14), .DIGITS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin      (bin),
      .bcd      (bcd),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; samples and drives land 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full conversion. Starts in an IDLE cycle and returns in the cycle
   // where done is high, so a following call exercises back-to-back starts.
   task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input logic [15:0] prev_bcd,
                           input string tag);
      bin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = ~v;                       // must not disturb the captured value
      check({tag, "_accept"}, {29'd0, busy, done, overflow == exp_ovf ? 1'b0 : 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
      for (int k = 1; k < 14; k++) begin
         tick();
         check({tag, "_run"}, {15'd0, busy, done, bcd}, {15'd0, 1'b1, 1'b0, prev_bcd});
      end
      tick();                           // FINISH cycle
      check({tag, "_finish"}, {15'd0, busy, done, bcd}, {15'd0, 1'b0, 1'b0, prev_bcd});
      tick();                           // result cycle
      check({tag, "_done"}, {14'd0, busy, done, overflow, bcd}, {14'd0, 1'b0, 1'b1, exp_ovf, exp_bcd});
      $display("conv %s bin=%0d bcd=%04h overflow=%0b done=%0b", tag, v, bcd, overflow, done);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      tick();
      tick();
      check("reset_state", {13'd0, busy, done, overflow, bcd}, 32'd0);
      reset = 1'b0;
      tick();
      $display("reset bcd=%04h busy=%0b done=%0b overflow=%0b", bcd, busy, done, overflow);

      // Back-to-back conversions; each start lands in the IDLE cycle after done.
      run_conv(14'd0,     16'h0000, 1'b0, 16'h0000, "zero");
      run_conv(14'd1234,  16'h1234, 1'b0, 16'h0000, "b1234");
      run_conv(14'd9999,  16'h9999, 1'b0, 16'h1234, "b9999");
      run_conv(14'd12000, 16'h9999, 1'b1, 16'h9999, "b12000");
      run_conv(14'd5,     16'h0005, 1'b0, 16'h9999, "b5");
      tick();
      check("done_single", {30'd0, busy, done}, 32'd0);

      // start pulsed while busy must be ignored.
      bin   = 14'd4321;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 15; k++) begin
         if (k == 5) begin
            bin   = 14'd7;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         check("busy_start_run", {15'd0, done, bcd}, {15'd0, 1'b0, 16'h0005});
      end
      tick();
      check("busy_start_done", {15'd0, done, bcd}, {15'd0, 1'b1, 16'h4321});
      $display("conv ignore_start bcd=%04h done=%0b", bcd, done);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("no_second_conv", {14'd0, busy, done, bcd}, {14'd0, 1'b0, 1'b0, 16'h4321});
      end

      // Reset in the middle of a conversion.
      bin   = 14'd8888;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 7; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset", {13'd0, busy, done, overflow, bcd}, 32'd0);
      $display("reset mid-conversion bcd=%04h busy=%0b", bcd, busy);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("post_reset_idle", {14'd0, busy, done, bcd}, 32'd0);
      end
      run_conv(14'd42, 16'h0042, 1'b0, 16'h0000, "b42");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
